// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Memory-stage load/store controller: registered data-memory
//            request with lane enables, misalignment and bus-timeout handling.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size_in,
    input  logic        u_load_in,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] RawData,
    output logic [1:0]  l_sel,
    output logic [1:0]  bhw_sel,
    output logic        u_load,
    output logic        load_valid
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam int              c_CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [1:0]      r_pend_size;
    logic [1:0]      r_pend_lsb;
    logic            r_pend_u;
    logic [31:0]     r_raw;
    logic [1:0]      r_l_sel;
    logic [1:0]      r_bhw_sel;
    logic            r_u_load;
    logic            r_load_valid;
    logic            r_misalign;
    logic            r_bus_err;

    logic        w_idle;
    logic        w_busy;
    logic        w_access;
    logic        w_aligned;
    logic        w_accept;
    logic        w_ack_busy;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_idle   = (r_state == c_IDLE);
    assign w_busy   = (r_state == c_BUSY);
    assign w_access = req_valid & (mem_read | mem_write);

    // Size 2'b11 falls into the word branch.
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = WriteData;
        case (size_in)
            2'b00: begin
                w_be    = 4'b0001 << ALUResult[1:0];
                w_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_aligned = ~ALUResult[0];
                w_be      = 4'b0011 << {ALUResult[1], 1'b0};
                w_wdata   = {2{WriteData[15:0]}};
            end
            default: begin
                w_aligned = (ALUResult[1:0] == 2'b00);
            end
        endcase
        if (!mem_write) begin
            w_wdata = 32'h0;
        end
    end

    assign w_accept   = w_idle & w_access & w_aligned;
    assign w_ack_busy = w_busy & dmem_ack;
    assign w_timeout  = w_busy & ~dmem_ack & (r_cnt == c_CNT_LAST);

    assign stall      = w_accept | (w_busy & ~dmem_ack);
    assign misalign   = r_misalign;
    assign bus_err    = r_bus_err;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign RawData    = r_raw;
    assign l_sel      = r_l_sel;
    assign bhw_sel    = r_bhw_sel;
    assign u_load     = r_u_load;
    assign load_valid = r_load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0;
            r_pend_size  <= 2'b00;
            r_pend_lsb   <= 2'b00;
            r_pend_u     <= 1'b0;
            r_raw        <= 32'h0;
            r_l_sel      <= 2'b00;
            r_bhw_sel    <= 2'b00;
            r_u_load     <= 1'b0;
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_misalign   <= w_idle & w_access & ~w_aligned;
            r_bus_err    <= w_timeout;
            r_load_valid <= w_ack_busy & ~r_we;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_BUSY;
                        r_cnt       <= '0;
                        r_req       <= 1'b1;
                        r_we        <= mem_write;
                        r_addr      <= {ALUResult[31:2], 2'b00};
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        r_pend_size <= size_in;
                        r_pend_lsb  <= ALUResult[1:0];
                        r_pend_u    <= u_load_in;
                    end
                end
                c_BUSY: begin
                    if (dmem_ack) begin
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        if (!r_we) begin
                            r_raw     <= dmem_rdata;
                            r_l_sel   <= r_pend_size;
                            r_bhw_sel <= r_pend_lsb;
                            r_u_load  <= r_pend_u;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Abandon the access; nothing is captured.
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
